// File: rtl/dac_pkg.sv
// Shared types and helpers for the multi-channel DAC serializer.
// Frame header width, FSM state encoding and SDI-to-offset-binary conversion.
package dac_pkg;

  localparam int HDR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_LOAD
  } st_e;

  // Two's complement to offset binary: flip the sign bit.
  function automatic logic [31:0] conv(input logic [31:0] d);
    return d ^ 32'h8000_0000;
  endfunction

endpackage

// File: rtl/dac_multi_ch_serializer_if.sv
// Frame handshake between channel sequencer and SPI shifter.
// The sequencer presents a frame with start; the shifter pulses done in its last GAP clk.
interface dac_frame_if #(
  parameter int FW = 24
);
  logic          start;
  logic [FW-1:0] data;
  logic          done;

  modport master (
    output start,
    output data,
    input  done
  );

  modport slave (
    input  start,
    input  data,
    output done
  );
endinterface

// File: rtl/dac_spi_shifter.sv
// Serializes one DAC frame: SETUP half-period, MSB-first SHIFT, GAP with sync high.
// All pin outputs are registered; done is high during the final GAP clk.
module dac_spi_shifter
  import dac_pkg::*;
#(
  parameter int DW      = 16,
  parameter int CLK_DIV = 4
) (
  input  logic      clk,
  input  logic      Reset,
  dac_frame_if.slave frm,
  output logic      sync_o,
  output logic      sclk_o,
  output logic      sdin_o
);

  localparam int FW   = HDR_W + DW;
  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV);
  localparam int BW   = $clog2(FW);

  st_e           st_q;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] bit_q;
  logic [FW-1:0] sh_q;
  logic          sync_q;
  logic          sclk_q;
  logic          done_q;

  assign sync_o   = sync_q;
  assign sclk_o   = sclk_q;
  assign sdin_o   = sh_q[FW-1];
  assign frm.done = done_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      sync_q <= 1'b1;
      sclk_q <= 1'b1;
      done_q <= 1'b0;
    end else if (frm.start) begin
      st_q   <= ST_SETUP;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= frm.data;
      sync_q <= 1'b0;
      sclk_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      unique case (st_q)
        ST_SETUP: begin
          if (cnt_q == CW'(HALF - 1)) begin
            st_q  <= ST_SHIFT;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          // Bit boundary: sclk rises and the next bit appears together.
          if (cnt_q == CW'(CLK_DIV - 1)) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
            if (bit_q == BW'(FW - 1)) begin
              st_q   <= ST_GAP;
              sync_q <= 1'b1;
              sh_q   <= '0;
            end else begin
              bit_q <= bit_q + 1'b1;
              sh_q  <= {sh_q[FW-2:0], 1'b0};
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(HALF - 1)) begin
              sclk_q <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          cnt_q  <= cnt_q + 1'b1;
          done_q <= (cnt_q == CW'(CLK_DIV - 2));
          if (cnt_q == CW'(CLK_DIV - 1)) begin
            st_q  <= ST_IDLE;
            cnt_q <= '0;
          end
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dac_multi_ch_serializer.sv
// Multi-channel DAC update engine: SDI capture, shadow snapshot on trigger,
// per-channel frame sequencing, load pulse and overrun accounting.
module dac_multi_ch_serializer
  import dac_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int DW       = 16,
  parameter int CLK_DIV  = 4,
  parameter int LOAD_CYC = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [9:0]        SdiAddr_i,
  input  logic [31:0]       SdiData_i,
  input  logic              SdiDataValid_i,
  input  logic [10*NCH-1:0] AddrSel_i,
  input  logic              trig_i,
  output logic              dacSync,
  output logic              dacSclk,
  output logic              dacSdin,
  output logic              dacLoad,
  output logic              busy,
  output logic [15:0]       overrun_cnt,
  output logic [DW*NCH-1:0] dac_code
);

  localparam int FW = HDR_W + DW;
  localparam int LW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

  st_e                     st_q;
  logic [2:0]              ch_q;
  logic [LW-1:0]           lcnt_q;
  logic                    trig_q;
  logic                    busy_q;
  logic                    load_q;
  logic [15:0]             ovr_q;
  logic [NCH-1:0][DW-1:0]  code_q;
  logic [NCH-1:0][DW-1:0]  shadow_q;

  logic                    edge_w;
  logic                    last_ch;
  logic [2:0]              ch_nx;
  logic [DW-1:0]           pay;
  logic [DW-1:0]           cap;

  dac_frame_if #(.FW(FW)) frm ();

  assign edge_w  = trig_i & ~trig_q;
  assign last_ch = (ch_q == 3'(NCH - 1));
  assign cap     = DW'(conv(SdiData_i) >> (32 - DW));

  // Frame 0 is sourced from the live registers because the
  // shadow bank is loaded on the same edge that starts it.
  always_comb begin
    ch_nx = (st_q == ST_IDLE) ? 3'd0 : ch_q + 3'd1;
    pay   = code_q[0];
    for (int k = 0; k < NCH; k++) begin
      if (st_q != ST_IDLE && ch_nx == 3'(k)) begin
        pay = shadow_q[k];
      end
    end
    frm.start = (st_q == ST_IDLE && edge_w) ||
                (st_q == ST_SHIFT && frm.done && !last_ch);
    frm.data  = {5'b00000, ch_nx, pay};
  end

  dac_spi_shifter #(
    .DW      (DW),
    .CLK_DIV (CLK_DIV)
  ) u_shf (
    .clk    (clk),
    .Reset  (Reset),
    .frm    (frm),
    .sync_o (dacSync),
    .sclk_o (dacSclk),
    .sdin_o (dacSdin)
  );

  assign dacLoad     = load_q;
  assign busy        = busy_q;
  assign overrun_cnt = ovr_q;
  assign dac_code    = code_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      st_q   <= ST_IDLE;
      ch_q   <= '0;
      lcnt_q <= '0;
      trig_q <= 1'b1;
      busy_q <= 1'b0;
      load_q <= 1'b1;
      ovr_q  <= '0;
      for (int k = 0; k < NCH; k++) begin
        code_q[k]   <= MID;
        shadow_q[k] <= MID;
      end
    end else begin
      trig_q <= trig_i;
      for (int k = 0; k < NCH; k++) begin
        if (SdiDataValid_i && SdiAddr_i == AddrSel_i[10*k +: 10]) begin
          code_q[k] <= cap;
        end
      end
      if (edge_w && busy_q && ovr_q != 16'hFFFF) begin
        ovr_q <= ovr_q + 16'd1;
      end
      // ST_SHIFT here spans all frames; the shifter owns per-frame phases.
      unique case (st_q)
        ST_IDLE: begin
          if (edge_w) begin
            st_q     <= ST_SHIFT;
            busy_q   <= 1'b1;
            ch_q     <= '0;
            shadow_q <= code_q;
          end
        end
        ST_SHIFT: begin
          if (frm.done) begin
            if (last_ch) begin
              st_q   <= ST_LOAD;
              load_q <= 1'b0;
              lcnt_q <= '0;
            end else begin
              ch_q <= ch_q + 3'd1;
            end
          end
        end
        ST_LOAD: begin
          if (lcnt_q == LW'(LOAD_CYC - 1)) begin
            st_q   <= ST_IDLE;
            load_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            lcnt_q <= lcnt_q + 1'b1;
          end
        end
        default: begin
          st_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_multi_ch_serializer.sv
// Randomized scoreboard bench for dac_multi_ch_serializer.
// A serial monitor decodes frames off the pins and checks them against queued expectations.
module tb_dac_multi_ch_serializer;

  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int CD  = 4;
  localparam int LC  = 2;
  localparam int FW  = 8 + DW;
  localparam int LEN = NCH * (CD / 2 + FW * CD + CD) + LC;

  logic              clk = 1'b0;
  logic              Reset = 1'b1;
  logic [9:0]        SdiAddr_i = '0;
  logic [31:0]       SdiData_i = '0;
  logic              SdiDataValid_i = 1'b0;
  logic [10*NCH-1:0] AddrSel_i;
  logic              trig_i = 1'b0;
  logic              dacSync, dacSclk, dacSdin, dacLoad, busy;
  logic [15:0]       overrun_cnt;
  logic [DW*NCH-1:0] dac_code;

  logic              trig2 = 1'b0;
  logic [9:0]        sel2 = 10'h011;
  logic              sync2, sclk2, sdin2, load2, busy2;
  logic [15:0]       ovr2;
  logic [19:0]       dac_code2;

  int          total = 0;
  int          bad = 0;
  int          seq_cnt = 0;
  int          regs_m[NCH];
  int          reg2_m;
  int          ovr_m;
  logic [9:0]  sel_m[NCH];
  logic [23:0] sb_q[$];
  logic [23:0] mon_sh;
  logic [23:0] mon_exp;
  int          mon_bits = 0;

  always #5 clk = ~clk;

  dac_multi_ch_serializer #(
    .NCH(NCH), .DW(DW), .CLK_DIV(CD), .LOAD_CYC(LC)
  ) dut (
    .clk(clk), .Reset(Reset), .SdiAddr_i(SdiAddr_i), .SdiData_i(SdiData_i),
    .SdiDataValid_i(SdiDataValid_i), .AddrSel_i(AddrSel_i), .trig_i(trig_i),
    .dacSync(dacSync), .dacSclk(dacSclk), .dacSdin(dacSdin), .dacLoad(dacLoad),
    .busy(busy), .overrun_cnt(overrun_cnt), .dac_code(dac_code)
  );

  dac_multi_ch_serializer #(
    .NCH(1), .DW(20), .CLK_DIV(CD), .LOAD_CYC(LC)
  ) dut20 (
    .clk(clk), .Reset(Reset), .SdiAddr_i(SdiAddr_i), .SdiData_i(SdiData_i),
    .SdiDataValid_i(SdiDataValid_i), .AddrSel_i(sel2), .trig_i(trig2),
    .dacSync(sync2), .dacSclk(sclk2), .dacSdin(sdin2), .dacLoad(load2),
    .busy(busy2), .overrun_cnt(ovr2), .dac_code(dac_code2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Signed value scaled to DW bits, then offset by half range.
  function automatic int conv_m(input logic [31:0] d, input int dw);
    return ($signed(d) >>> (32 - dw)) + (1 << (dw - 1));
  endfunction

  function automatic void model_cap(input logic [9:0] a, input logic [31:0] d);
    for (int k = 0; k < NCH; k++)
      if (sel_m[k] == a) regs_m[k] = conv_m(d, DW);
    if (sel2 == a) reg2_m = conv_m(d, 20);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) regs_m[k] = 1 << (DW - 1);
    reg2_m = 1 << 19;
    ovr_m  = 0;
  endfunction

  function automatic void set_sel();
    for (int k = 0; k < NCH; k++) AddrSel_i[10*k +: 10] = sel_m[k];
  endfunction

  always @(posedge busy) seq_cnt++;

  always @(negedge dacSclk or posedge dacSync) begin
    if (dacSync) begin
      mon_bits = 0;
    end else begin
      mon_sh = {mon_sh[22:0], dacSdin};
      mon_bits++;
      if (mon_bits == FW) begin
        mon_bits = 0;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_unexpected got=%0h want=none", mon_sh);
        end else begin
          mon_exp = sb_q.pop_front();
          chk("frame", mon_sh, mon_exp);
        end
      end
    end
  end

  task automatic check_codes();
    for (int k = 0; k < NCH; k++)
      chk($sformatf("code_ch%0d", k), dac_code[DW*k +: DW], regs_m[k]);
    chk("code_dw20", dac_code2, reg2_m);
  endtask

  task automatic drive(input logic [9:0] a, input logic [31:0] d);
    SdiAddr_i = a;
    SdiData_i = d;
    SdiDataValid_i = 1'b1;
  endtask

  task automatic capture(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(a, d);
    @(negedge clk);
    SdiDataValid_i = 1'b0;
    model_cap(a, d);
    check_codes();
  endtask

  task automatic push_frames();
    for (int k = 0; k < NCH; k++)
      sb_q.push_back(24'((k << DW) + regs_m[k]));
  endtask

  task automatic run_seq(input int cap_at, input logic [9:0] a, input logic [31:0] d,
                         input int extra, input bit late);
    int n, lo, s0;
    s0 = seq_cnt;
    push_frames();
    @(negedge clk);
    trig_i = 1'b1;
    if (cap_at == 0) drive(a, d);
    @(negedge clk);
    trig_i = 1'b0;
    if (SdiDataValid_i) begin
      SdiDataValid_i = 1'b0;
      model_cap(a, d);
    end
    chk("busy_rise", busy, 1);
    n = 0;
    lo = 0;
    for (int c = 1; c < 4000 && busy; c++) begin
      n++;
      if (!dacLoad) lo++;
      if (c == cap_at) drive(a, d);
      if (c >= 10 && c < 10 + 2 * extra) trig_i = ~trig_i;
      if (late && n == LEN) trig_i = 1'b1;
      @(negedge clk);
      if (SdiDataValid_i) begin
        SdiDataValid_i = 1'b0;
        model_cap(a, d);
      end
    end
    ovr_m += extra + int'(late);
    chk("seq_len", n, LEN);
    chk("load_width", lo, LC);
    trig_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("seq_count", seq_cnt - s0, 1);
    chk("frames_left", sb_q.size(), 0);
    chk("overrun", overrun_cnt, ovr_m);
    check_codes();
  endtask

  initial begin
    sel_m[0] = 10'h011;
    sel_m[1] = 10'h022;
    sel_m[2] = 10'h033;
    set_sel();
    model_reset();

    trig_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sync", dacSync, 1);
    chk("rst_sclk", dacSclk, 1);
    chk("rst_sdin", dacSdin, 0);
    chk("rst_load", dacLoad, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_code", dac_code, 48'h8000_8000_8000);
    Reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("trig_held_reset", busy, 0);
    trig_i = 1'b0;
    repeat (2) @(negedge clk);

    capture(10'h022, 32'h4000_0000);
    chk("ch1_c000", dac_code[31:16], 16'hC000);
    chk("frame1_expect", 24'((1 << DW) + regs_m[1]), 24'h01C000);
    run_seq(-1, '0, '0, 0, 1'b0);

    capture(10'h011, 32'h8000_0000);
    chk("dw20_min", dac_code2, 20'h00000);
    capture(10'h011, 32'h7FFF_FFFF);
    chk("dw20_max", dac_code2, 20'hFFFFF);
    capture(10'h011, 32'h0000_0000);
    chk("dw20_mid", dac_code2, 20'h80000);

    for (int i = 0; i < 10; i++) begin
      logic [9:0] a;
      a = (i % 4 == 3) ? 10'($urandom_range(64, 1023)) : sel_m[$urandom_range(0, NCH - 1)];
      capture(a, $urandom);
    end
    run_seq(-1, '0, '0, 0, 1'b0);

    run_seq(20, 10'h011, $urandom, 0, 1'b0);
    run_seq(-1, '0, '0, 0, 1'b0);
    run_seq(0, 10'h033, $urandom, 0, 1'b0);
    run_seq(-1, '0, '0, 0, 1'b0);

    run_seq(-1, '0, '0, 3, 1'b0);
    run_seq(-1, '0, '0, 0, 1'b0);
    chk("ovr_three", overrun_cnt, 16'd3);
    run_seq(-1, '0, '0, 0, 1'b1);

    sel_m[2] = 10'h011;
    set_sel();
    capture(10'h011, $urandom);
    capture(10'h022, $urandom);
    run_seq(-1, '0, '0, 0, 1'b0);

    push_frames();
    @(negedge clk);
    trig_i = 1'b1;
    @(negedge clk);
    trig_i = 1'b0;
    repeat (150) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    model_reset();
    chk("midrst_sync", dacSync, 1);
    chk("midrst_sclk", dacSclk, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_load", dacLoad, 1);
    chk("midrst_ovr", overrun_cnt, 0);
    check_codes();
    sb_q.delete();
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    run_seq(-1, '0, '0, 0, 1'b0);
    chk("dw20_idle", busy2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
